// File: rtl/ripple_count_sampler.sv
// Brings the asynchronous 4-bit ripple count into clk: synchronizes it, filters it, adds wrap-count
// extension bits and hands out snapshots over valid/ready. RIPPLE_COUNT_SAMPLER_OVF_EN builds ovf.
module ripple_count_sampler #(
  parameter int unsigned EXT_W      = 4,
  parameter int unsigned STABLE_CYC = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [3:0]         cnt_in,
  input  logic               sample_req,
  output logic [3+EXT_W:0]   out_count,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               wrap_pulse,
  output logic               ovf
);

  // s2 is the newest history entry, so only STABLE_CYC-1 older copies are stored.
  localparam int unsigned HistDepth = STABLE_CYC - 1;

  typedef enum logic [1:0] {StIdle, StCapture, StHold} state_e;

  logic [3:0]                s1_q, s2_q;
  logic [HistDepth-1:0][3:0] hist_q;
  logic [3:0]                stable_q, stable_d;
  logic [EXT_W-1:0]          ext_q, ext_d;
  logic                      wrap_q, wrap_d;
  logic                      all_eq;

  state_e                    state_q;
  logic [3+EXT_W:0]          out_count_q;
  logic                      out_valid_q;

  always_comb begin
    all_eq = 1'b1;
    for (int i = 0; i < HistDepth; i++) begin
      if (hist_q[i] != s2_q) all_eq = 1'b0;
    end
  end

  // A drop in value on a load can only be a 4-bit wrap within the operating range.
  always_comb begin
    stable_d = stable_q;
    ext_d    = ext_q;
    wrap_d   = 1'b0;
    if (all_eq && (s2_q != stable_q)) begin
      stable_d = s2_q;
      if (s2_q < stable_q) begin
        ext_d  = ext_q + EXT_W'(1);
        wrap_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_q     <= '0;
      s2_q     <= '0;
      hist_q   <= '0;
      stable_q <= '0;
      ext_q    <= '0;
      wrap_q   <= 1'b0;
    end else begin
      s1_q      <= cnt_in;
      s2_q      <= s1_q;
      hist_q[0] <= s2_q;
      for (int i = 1; i < HistDepth; i++) begin
        hist_q[i] <= hist_q[i-1];
      end
      stable_q <= stable_d;
      ext_q    <= ext_d;
      wrap_q   <= wrap_d;
    end
  end

  // Snapshot reads the registered {ext, stable}, so it always sees a consistent pre-update pair.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      out_count_q <= '0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (sample_req) state_q <= StCapture;
        end
        StCapture: begin
          out_count_q <= {ext_q, stable_q};
          out_valid_q <= 1'b1;
          state_q     <= StHold;
        end
        StHold: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= sample_req ? StCapture : StIdle;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          state_q     <= StIdle;
        end
      endcase
    end
  end

`ifdef RIPPLE_COUNT_SAMPLER_OVF_EN
  logic ovf_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ovf_q <= 1'b0;
    end else if (sample_req &&
                 ((state_q == StCapture) || ((state_q == StHold) && !out_ready))) begin
      ovf_q <= 1'b1;
    end
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

  assign out_count  = out_count_q;
  assign out_valid  = out_valid_q;
  assign wrap_pulse = wrap_q;

endmodule

// File: tb/tb_ripple_count_sampler.sv
// Directed bench for ripple_count_sampler at default parameters: table of hold/snapshot rows plus
// hand-written sequences for filtering, reset, backpressure, back-to-back and overflow.
module tb_ripple_count_sampler;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] cnt_in;
  logic       sample_req;
  logic       out_ready;
  logic [7:0] out_count;
  logic       out_valid;
  logic       wrap_pulse;
  logic       ovf;

  int   tests = 0;
  int   fails = 0;
  int   wraps = 0;
  logic exp_ovf;

  typedef struct {
    logic [3:0]  cnt;
    int unsigned hold;
    int unsigned exp_wraps;
    logic [7:0]  exp_snap;
  } vec_t;

  vec_t vecs[9];

  ripple_count_sampler dut (
    .clk        (clk),
    .reset      (reset),
    .cnt_in     (cnt_in),
    .sample_req (sample_req),
    .out_count  (out_count),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .wrap_pulse (wrap_pulse),
    .ovf        (ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (wrap_pulse === 1'b1) wraps++;
  endtask

  task automatic drive(input logic [3:0] c, input logic r, input logic rdy);
    cnt_in     = c;
    sample_req = r;
    out_ready  = rdy;
  endtask

  task automatic hold_cnt(input logic [3:0] c, input int unsigned n);
    drive(c, 1'b0, 1'b1);
    repeat (n) tick();
  endtask

  task automatic apply_reset();
    drive(4'd0, 1'b0, 1'b1);
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  // Request in IDLE, observe HOLD one edge later, then complete the handshake.
  task automatic snapshot(input string name, input logic [7:0] exp);
    drive(cnt_in, 1'b1, 1'b1);
    tick();
    drive(cnt_in, 1'b0, 1'b1);
    tick();
    check({name, "_valid"}, 32'(out_valid), 32'd1);
    check({name, "_count"}, 32'(out_count), 32'(exp));
    tick();
    check({name, "_done"}, 32'(out_valid), 32'd0);
  endtask

  // j: edges after the hold-at-4 begins when sample_req is sampled; capture is one edge later.
  task automatic filter_run(input int j, input logic [7:0] exp);
    apply_reset();
    wraps = 0;
    hold_cnt(4'd3, 8);
    for (int i = 0; i < 10; i++) hold_cnt((i % 2 == 0) ? 4'd4 : 4'd3, 1);
    for (int n = 0; n <= j + 2; n++) begin
      drive(4'd4, (n == j), 1'b1);
      tick();
      if (n == j + 1) begin
        check($sformatf("filter_j%0d_valid", j), 32'(out_valid), 32'd1);
        check($sformatf("filter_j%0d_count", j), 32'(out_count), 32'(exp));
      end
      if (n == j + 2) check($sformatf("filter_j%0d_done", j), 32'(out_valid), 32'd0);
    end
    check($sformatf("filter_j%0d_wraps", j), 32'(wraps), 32'd0);
  endtask

  initial begin
`ifdef RIPPLE_COUNT_SAMPLER_OVF_EN
    exp_ovf = 1'b1;
`else
    exp_ovf = 1'b0;
`endif
    vecs[0] = '{cnt: 4'd14, hold: 8, exp_wraps: 0, exp_snap: 8'h0E};
    vecs[1] = '{cnt: 4'd15, hold: 8, exp_wraps: 0, exp_snap: 8'h0F};
    vecs[2] = '{cnt: 4'd0,  hold: 8, exp_wraps: 1, exp_snap: 8'h10};
    vecs[3] = '{cnt: 4'd1,  hold: 8, exp_wraps: 0, exp_snap: 8'h11};
    vecs[4] = '{cnt: 4'd9,  hold: 8, exp_wraps: 0, exp_snap: 8'h19};
    vecs[5] = '{cnt: 4'd2,  hold: 8, exp_wraps: 1, exp_snap: 8'h22};
    vecs[6] = '{cnt: 4'd2,  hold: 8, exp_wraps: 0, exp_snap: 8'h22};
    vecs[7] = '{cnt: 4'd7,  hold: 8, exp_wraps: 0, exp_snap: 8'h27};
    vecs[8] = '{cnt: 4'd5,  hold: 8, exp_wraps: 1, exp_snap: 8'h35};

    reset = 1'b0;
    drive(4'd0, 1'b0, 1'b1);
    tick();
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_count", 32'(out_count), 32'd0);
    check("rst_wrap", 32'(wrap_pulse), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);

    filter_run(2, 8'h03);
    filter_run(3, 8'h04);

    apply_reset();
    for (int i = 0; i < 9; i++) begin
      wraps = 0;
      hold_cnt(vecs[i].cnt, vecs[i].hold);
      snapshot($sformatf("row%0d", i), vecs[i].exp_snap);
      check($sformatf("row%0d_wraps", i), 32'(wraps), 32'(vecs[i].exp_wraps));
    end

    // Reset asserted mid-HOLD between clock edges.
    drive(4'd5, 1'b1, 1'b0);
    tick();
    drive(4'd5, 1'b0, 1'b0);
    tick();
    tick();
    check("hold_valid", 32'(out_valid), 32'd1);
    check("hold_count", 32'(out_count), 32'h35);
    drive(4'd0, 1'b0, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    check("async_rst_valid", 32'(out_valid), 32'd0);
    check("async_rst_count", 32'(out_count), 32'd0);
    check("async_rst_wrap", 32'(wrap_pulse), 32'd0);
    check("async_rst_ovf", 32'(ovf), 32'd0);
    tick();
    reset = 1'b1;
    snapshot("post_rst", 8'h00);

    // 17 wraps from ext=0 pass through all-ones back to 1.
    wraps = 0;
    for (int i = 0; i < 17; i++) begin
      hold_cnt(4'd8, 8);
      hold_cnt(4'd0, 8);
    end
    check("ext_wraps", 32'(wraps), 32'd17);
    snapshot("ext_roll", 8'h10);

    // Backpressure: snapshot stays frozen while the count moves underneath.
    drive(4'd0, 1'b1, 1'b0);
    tick();
    drive(4'd0, 1'b0, 1'b0);
    tick();
    check("bp_valid0", 32'(out_valid), 32'd1);
    check("bp_count0", 32'(out_count), 32'h10);
    for (int i = 0; i < 5; i++) begin
      drive(4'd6, 1'b0, 1'b0);
      tick();
      check($sformatf("bp_valid%0d", i + 1), 32'(out_valid), 32'd1);
      check($sformatf("bp_count%0d", i + 1), 32'(out_count), 32'h10);
    end
    drive(4'd6, 1'b0, 1'b1);
    tick();
    check("bp_after_hs", 32'(out_valid), 32'd0);
    drive(4'd6, 1'b0, 1'b0);
    tick();
    check("bp_idle", 32'(out_valid), 32'd0);
    snapshot("bp_next", 8'h16);

    // Back-to-back: valid goes 1, 0, 1 and the second snapshot is fresh.
    drive(4'd6, 1'b1, 1'b0);
    tick();
    drive(4'd6, 1'b0, 1'b0);
    tick();
    check("b2b_valid_a", 32'(out_valid), 32'd1);
    check("b2b_count_a", 32'(out_count), 32'h16);
    hold_cnt(4'd9, 0);
    drive(4'd9, 1'b0, 1'b0);
    repeat (6) tick();
    check("b2b_frozen", 32'(out_count), 32'h16);
    drive(4'd9, 1'b1, 1'b1);
    tick();
    check("b2b_valid_gap", 32'(out_valid), 32'd0);
    drive(4'd9, 1'b0, 1'b0);
    tick();
    check("b2b_valid_b", 32'(out_valid), 32'd1);
    check("b2b_count_b", 32'(out_count), 32'h19);
    drive(4'd9, 1'b0, 1'b1);
    tick();
    check("b2b_done", 32'(out_valid), 32'd0);

    // Overflow: request dropped while HOLD is backpressured.
    check("ovf_before", 32'(ovf), 32'd0);
    drive(4'd9, 1'b1, 1'b0);
    tick();
    drive(4'd9, 1'b0, 1'b0);
    tick();
    drive(4'd9, 1'b1, 1'b0);
    tick();
    check("ovf_set", 32'(ovf), 32'(exp_ovf));
    check("ovf_hold_valid", 32'(out_valid), 32'd1);
    drive(4'd9, 1'b0, 1'b1);
    tick();
    check("ovf_after_hs", 32'(ovf), 32'(exp_ovf));
    check("ovf_hs_valid", 32'(out_valid), 32'd0);
    snapshot("ovf_snap", 8'h19);
    check("ovf_sticky", 32'(ovf), 32'(exp_ovf));
    apply_reset();
    check("ovf_cleared", 32'(ovf), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
